// File: rtl/instr_decoder_pkg.sv
// Shared encodings for the MIPS main control decoder: opcode/funct values,
// control-field encodings, the ERET word and the packed control bundle.
package instr_decoder_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_COP0   = 6'h10;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // COP0 rs sub-codes
  localparam logic [4:0] RS_MF = 5'b00000;
  localparam logic [4:0] RS_MT = 5'b00100;

  // ALU operations
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;

  // Write-back source
  localparam logic [2:0] WD_ALU  = 3'd0;
  localparam logic [2:0] WD_MEM  = 3'd1;
  localparam logic [2:0] WD_PC8  = 3'd2;
  localparam logic [2:0] WD_HILO = 3'd3;
  localparam logic [2:0] WD_CP0  = 3'd4;

  // Destination register select
  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  // Immediate extension
  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  // Memory access size
  localparam logic [1:0] MS_WORD = 2'd0;
  localparam logic [1:0] MS_HALF = 2'd1;
  localparam logic [1:0] MS_BYTE = 2'd2;

  // Branch type
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLEZ = 3'd3;
  localparam logic [2:0] BR_BGTZ = 3'd4;
  localparam logic [2:0] BR_BLTZ = 3'd5;
  localparam logic [2:0] BR_BGEZ = 3'd6;

  // Jump type
  localparam logic [1:0] J_NONE = 2'd0;
  localparam logic [1:0] J_IMM  = 2'd1;
  localparam logic [1:0] J_REG  = 2'd2;

  // Multiply/divide unit operation
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  localparam logic [31:0] ERET_WORD = 32'h4200_0018;
  localparam logic [4:0]  EXC_RI    = 5'd10;

  // Complete decoded control bundle
  typedef struct packed {
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [2:0] wd_sel;
    logic       alu_src_b;
    logic [1:0] ext_op;
    logic [3:0] alu_op;
    logic       shamt_sel;
    logic       ov_check;
    logic       mem_we;
    logic       mem_load;
    logic [1:0] mem_size;
    logic       load_sign;
    logic [2:0] br_type;
    logic [1:0] j_type;
    logic [3:0] md_op;
    logic       bor_j;
    logic       cp0_we;
    logic       mfc0;
    logic       eret;
    logic       ri;
  } ctrl_t;

  // NOP-equivalent controls with the reserved-instruction flag raised
  function automatic ctrl_t illegal_ctrl();
    ctrl_t c;
    c    = '0;
    c.ri = 1'b1;
    return c;
  endfunction

  // Register-register ALU instruction writing rd
  function automatic ctrl_t r_alu(input logic [3:0] op, input logic shamt_sel);
    ctrl_t c;
    c           = '0;
    c.reg_we    = 1'b1;
    c.reg_dst   = RD_RD;
    c.wd_sel    = WD_ALU;
    c.alu_op    = op;
    c.shamt_sel = shamt_sel;
    return c;
  endfunction

  // Immediate ALU instruction writing rt
  function automatic ctrl_t i_alu(input logic [1:0] ext, input logic [3:0] op);
    ctrl_t c;
    c           = '0;
    c.reg_we    = 1'b1;
    c.reg_dst   = RD_RT;
    c.wd_sel    = WD_ALU;
    c.alu_src_b = 1'b1;
    c.ext_op    = ext;
    c.alu_op    = op;
    return c;
  endfunction

  // Load (is_load=1) or store; address is base + sign-extended offset
  function automatic ctrl_t mem_ctrl(input logic is_load, input logic [1:0] size,
                                     input logic sign);
    ctrl_t c;
    c           = '0;
    c.alu_src_b = 1'b1;
    c.ext_op    = EXT_SIGN;
    c.alu_op    = ALU_ADD;
    c.mem_size  = size;
    if (is_load) begin
      c.reg_we    = 1'b1;
      c.reg_dst   = RD_RT;
      c.wd_sel    = WD_MEM;
      c.mem_load  = 1'b1;
      c.load_sign = sign;
    end else begin
      c.mem_we    = 1'b1;
    end
    return c;
  endfunction

  // Conditional branch
  function automatic ctrl_t branch(input logic [2:0] br);
    ctrl_t c;
    c         = '0;
    c.br_type = br;
    c.bor_j   = 1'b1;
    return c;
  endfunction

  // Multiply/divide unit access; wb=1 for mfhi/mflo which write rd
  function automatic ctrl_t md_ctrl(input logic [3:0] op, input logic wb);
    ctrl_t c;
    c       = '0;
    c.md_op = op;
    if (wb) begin
      c.reg_we  = 1'b1;
      c.reg_dst = RD_RD;
      c.wd_sel  = WD_HILO;
    end else begin
      c.reg_we  = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Main control decoder for the 5-stage MIPS pipeline with CP0.
// Combinational decode of Instr plus a one-cycle registered copy of the
// RI/ERET/CP0WE/BorJ flags for the following stage.
// Optional feature macro: DECODER_MDU_EN (mult/div/hi/lo instructions).
module instr_decoder
  import instr_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  output logic        RegWE,
  output logic [1:0]  RegDst,
  output logic [2:0]  WDSel,
  output logic        ALUSrcB,
  output logic [1:0]  ExtOp,
  output logic [3:0]  ALUOp,
  output logic        ShamtSel,
  output logic        OvCheck,
  output logic        MemWE,
  output logic        MemLoad,
  output logic [1:0]  MemSize,
  output logic        LoadSign,
  output logic [2:0]  BrType,
  output logic [1:0]  JType,
  output logic [3:0]  MDOp,
  output logic        BorJ,
  output logic        CP0WE,
  output logic        MFC0,
  output logic        ERET,
  output logic        RI,
  output logic        RI_q,
  output logic        ERET_q,
  output logic        CP0WE_q,
  output logic        BorJ_q
);

  logic [5:0] opcode_s;
  logic [4:0] rs_s;
  logic [4:0] rt_s;
  logic [5:0] funct_s;
  ctrl_t      ctrl_s;
  logic [3:0] flags_d;
  logic [3:0] flags_q;

  assign opcode_s = Instr[31:26];
  assign rs_s     = Instr[25:21];
  assign rt_s     = Instr[20:16];
  assign funct_s  = Instr[5:0];

  // Instruction decode: anything not matched falls to the illegal bundle
  always_comb begin
    ctrl_s = illegal_ctrl();
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD:  begin ctrl_s = r_alu(ALU_ADD, 1'b0); ctrl_s.ov_check = 1'b1; end
          FN_ADDU: ctrl_s = r_alu(ALU_ADD, 1'b0);
          FN_SUB:  begin ctrl_s = r_alu(ALU_SUB, 1'b0); ctrl_s.ov_check = 1'b1; end
          FN_SUBU: ctrl_s = r_alu(ALU_SUB, 1'b0);
          FN_AND:  ctrl_s = r_alu(ALU_AND, 1'b0);
          FN_OR:   ctrl_s = r_alu(ALU_OR, 1'b0);
          FN_XOR:  ctrl_s = r_alu(ALU_XOR, 1'b0);
          FN_NOR:  ctrl_s = r_alu(ALU_NOR, 1'b0);
          FN_SLT:  ctrl_s = r_alu(ALU_SLT, 1'b0);
          FN_SLTU: ctrl_s = r_alu(ALU_SLTU, 1'b0);
          FN_SLL:  ctrl_s = r_alu(ALU_SLL, 1'b0);
          FN_SRL:  ctrl_s = r_alu(ALU_SRL, 1'b0);
          FN_SRA:  ctrl_s = r_alu(ALU_SRA, 1'b0);
          FN_SLLV: ctrl_s = r_alu(ALU_SLL, 1'b1);
          FN_SRLV: ctrl_s = r_alu(ALU_SRL, 1'b1);
          FN_SRAV: ctrl_s = r_alu(ALU_SRA, 1'b1);
          FN_JR: begin
            ctrl_s        = '0;
            ctrl_s.j_type = J_REG;
            ctrl_s.bor_j  = 1'b1;
          end
          FN_JALR: begin
            ctrl_s         = '0;
            ctrl_s.reg_we  = 1'b1;
            ctrl_s.reg_dst = RD_RD;
            ctrl_s.wd_sel  = WD_PC8;
            ctrl_s.j_type  = J_REG;
            ctrl_s.bor_j   = 1'b1;
          end
`ifdef DECODER_MDU_EN
          FN_MULT:  ctrl_s = md_ctrl(MD_MULT, 1'b0);
          FN_MULTU: ctrl_s = md_ctrl(MD_MULTU, 1'b0);
          FN_DIV:   ctrl_s = md_ctrl(MD_DIV, 1'b0);
          FN_DIVU:  ctrl_s = md_ctrl(MD_DIVU, 1'b0);
          FN_MTHI:  ctrl_s = md_ctrl(MD_MTHI, 1'b0);
          FN_MTLO:  ctrl_s = md_ctrl(MD_MTLO, 1'b0);
          FN_MFHI:  ctrl_s = md_ctrl(MD_MFHI, 1'b1);
          FN_MFLO:  ctrl_s = md_ctrl(MD_MFLO, 1'b1);
`else
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
          FN_MTHI, FN_MTLO, FN_MFHI, FN_MFLO: ctrl_s = illegal_ctrl();
`endif
          default: ctrl_s = illegal_ctrl();
        endcase
      end
      OP_REGIMM: begin
        case (rt_s)
          5'd0:    ctrl_s = branch(BR_BLTZ);
          5'd1:    ctrl_s = branch(BR_BGEZ);
          default: ctrl_s = illegal_ctrl();
        endcase
      end
      OP_J: begin
        ctrl_s        = '0;
        ctrl_s.j_type = J_IMM;
        ctrl_s.bor_j  = 1'b1;
      end
      OP_JAL: begin
        ctrl_s         = '0;
        ctrl_s.reg_we  = 1'b1;
        ctrl_s.reg_dst = RD_RA;
        ctrl_s.wd_sel  = WD_PC8;
        ctrl_s.j_type  = J_IMM;
        ctrl_s.bor_j   = 1'b1;
      end
      OP_BEQ:   ctrl_s = branch(BR_BEQ);
      OP_BNE:   ctrl_s = branch(BR_BNE);
      OP_BLEZ:  ctrl_s = branch(BR_BLEZ);
      OP_BGTZ:  ctrl_s = branch(BR_BGTZ);
      OP_ADDI:  begin ctrl_s = i_alu(EXT_SIGN, ALU_ADD); ctrl_s.ov_check = 1'b1; end
      OP_ADDIU: ctrl_s = i_alu(EXT_SIGN, ALU_ADD);
      OP_SLTI:  ctrl_s = i_alu(EXT_SIGN, ALU_SLT);
      OP_SLTIU: ctrl_s = i_alu(EXT_SIGN, ALU_SLTU);
      OP_ANDI:  ctrl_s = i_alu(EXT_ZERO, ALU_AND);
      OP_ORI:   ctrl_s = i_alu(EXT_ZERO, ALU_OR);
      OP_XORI:  ctrl_s = i_alu(EXT_ZERO, ALU_XOR);
      // lui: immediate already shifted by the extender, OR'd with rs ($0)
      OP_LUI:   ctrl_s = i_alu(EXT_LUI, ALU_OR);
      OP_LW:    ctrl_s = mem_ctrl(1'b1, MS_WORD, 1'b0);
      OP_LH:    ctrl_s = mem_ctrl(1'b1, MS_HALF, 1'b1);
      OP_LHU:   ctrl_s = mem_ctrl(1'b1, MS_HALF, 1'b0);
      OP_LB:    ctrl_s = mem_ctrl(1'b1, MS_BYTE, 1'b1);
      OP_LBU:   ctrl_s = mem_ctrl(1'b1, MS_BYTE, 1'b0);
      OP_SW:    ctrl_s = mem_ctrl(1'b0, MS_WORD, 1'b0);
      OP_SH:    ctrl_s = mem_ctrl(1'b0, MS_HALF, 1'b0);
      OP_SB:    ctrl_s = mem_ctrl(1'b0, MS_BYTE, 1'b0);
      OP_COP0: begin
        // eret is matched on the whole word; other CO-space words are illegal
        if (Instr == ERET_WORD) begin
          ctrl_s      = '0;
          ctrl_s.eret = 1'b1;
        end else begin
          case (rs_s)
            RS_MF: begin
              ctrl_s         = '0;
              ctrl_s.reg_we  = 1'b1;
              ctrl_s.reg_dst = RD_RT;
              ctrl_s.wd_sel  = WD_CP0;
              ctrl_s.mfc0    = 1'b1;
            end
            RS_MT: begin
              ctrl_s        = '0;
              ctrl_s.cp0_we = 1'b1;
            end
            default: ctrl_s = illegal_ctrl();
          endcase
        end
      end
      default: ctrl_s = illegal_ctrl();
    endcase
  end

  assign RegWE    = ctrl_s.reg_we;
  assign RegDst   = ctrl_s.reg_dst;
  assign WDSel    = ctrl_s.wd_sel;
  assign ALUSrcB  = ctrl_s.alu_src_b;
  assign ExtOp    = ctrl_s.ext_op;
  assign ALUOp    = ctrl_s.alu_op;
  assign ShamtSel = ctrl_s.shamt_sel;
  assign OvCheck  = ctrl_s.ov_check;
  assign MemWE    = ctrl_s.mem_we;
  assign MemLoad  = ctrl_s.mem_load;
  assign MemSize  = ctrl_s.mem_size;
  assign LoadSign = ctrl_s.load_sign;
  assign BrType   = ctrl_s.br_type;
  assign JType    = ctrl_s.j_type;
  assign MDOp     = ctrl_s.md_op;
  assign BorJ     = ctrl_s.bor_j;
  assign CP0WE    = ctrl_s.cp0_we;
  assign MFC0     = ctrl_s.mfc0;
  assign ERET     = ctrl_s.eret;
  assign RI       = ctrl_s.ri;

  // Next value of the forwarded exception/CP0 flags
  always_comb begin
    flags_d = {ctrl_s.ri, ctrl_s.eret, ctrl_s.cp0_we, ctrl_s.bor_j};
  end

  // One-cycle flag pipeline register; reset has priority over new data
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign RI_q    = flags_q[3];
  assign ERET_q  = flags_q[2];
  assign CP0WE_q = flags_q[1];
  assign BorJ_q  = flags_q[0];

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: table of instruction words with
// hand-decoded control bundles, plus sequences for the registered flags.
module tb_instr_decoder;

  typedef struct packed {
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [2:0] wd_sel;
    logic       alu_src_b;
    logic [1:0] ext_op;
    logic [3:0] alu_op;
    logic       shamt_sel;
    logic       ov_check;
    logic       mem_we;
    logic       mem_load;
    logic [1:0] mem_size;
    logic       load_sign;
    logic [2:0] br_type;
    logic [1:0] j_type;
    logic [3:0] md_op;
    logic       bor_j;
    logic       cp0_we;
    logic       mfc0;
    logic       eret;
    logic       ri;
  } ctl_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    ctl_t        exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic        RegWE, ALUSrcB, ShamtSel, OvCheck, MemWE, MemLoad, LoadSign;
  logic        BorJ, CP0WE, MFC0, ERET, RI;
  logic        RI_q, ERET_q, CP0WE_q, BorJ_q;
  logic [1:0]  RegDst, ExtOp, MemSize, JType;
  logic [2:0]  WDSel, BrType;
  logic [3:0]  ALUOp, MDOp;
  ctl_t        act;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];

  instr_decoder dut (
    .clk(clk), .reset(reset), .Instr(Instr),
    .RegWE(RegWE), .RegDst(RegDst), .WDSel(WDSel), .ALUSrcB(ALUSrcB),
    .ExtOp(ExtOp), .ALUOp(ALUOp), .ShamtSel(ShamtSel), .OvCheck(OvCheck),
    .MemWE(MemWE), .MemLoad(MemLoad), .MemSize(MemSize), .LoadSign(LoadSign),
    .BrType(BrType), .JType(JType), .MDOp(MDOp), .BorJ(BorJ),
    .CP0WE(CP0WE), .MFC0(MFC0), .ERET(ERET), .RI(RI),
    .RI_q(RI_q), .ERET_q(ERET_q), .CP0WE_q(CP0WE_q), .BorJ_q(BorJ_q)
  );

  assign act = {RegWE, RegDst, WDSel, ALUSrcB, ExtOp, ALUOp, ShamtSel, OvCheck,
                MemWE, MemLoad, MemSize, LoadSign, BrType, JType, MDOp, BorJ,
                CP0WE, MFC0, ERET, RI};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void add(input string n, input logic [31:0] i, input ctl_t e);
    vec_t v;
    v.name = n; v.instr = i; v.exp = e;
    tbl.push_back(v);
  endfunction

  function automatic logic [3:0] flags_of(input ctl_t e);
    return {e.ri, e.eret, e.cp0_we, e.bor_j};
  endfunction

  initial begin
    ctl_t e;
    // ---------------- vector table ----------------
    e = '0; e.cp0_we = 1'b1;                                   add("mtc0", 32'h40806000, e);
    e = '0; e.eret = 1'b1;                                     add("eret", 32'h42000018, e);
    e = '0; e.ri = 1'b1;                                       add("eret_bad", 32'h42000019, e);
    e = '0; e.reg_we = 1'b1; e.wd_sel = 3'd4; e.mfc0 = 1'b1;   add("mfc0", 32'h40086000, e);
    e = '0; e.ri = 1'b1;                                       add("cop0_rs1", 32'h40286000, e);
    e = '0; e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wd_sel = 3'd2; e.j_type = 2'd1; e.bor_j = 1'b1;
    add("jal", 32'h0C000004, e);
    e = '0; e.j_type = 2'd1; e.bor_j = 1'b1;                   add("j", 32'h08000004, e);
    e = '0; e.reg_we = 1'b1; e.wd_sel = 3'd1; e.alu_src_b = 1'b1; e.ext_op = 2'd1; e.mem_load = 1'b1;
    add("lw", 32'h8C410004, e);
    e = '0; e.reg_we = 1'b1; e.wd_sel = 3'd1; e.alu_src_b = 1'b1; e.ext_op = 2'd1; e.mem_load = 1'b1;
    e.mem_size = 2'd2; e.load_sign = 1'b1;                     add("lb", 32'h80410000, e);
    e = '0; e.reg_we = 1'b1; e.wd_sel = 3'd1; e.alu_src_b = 1'b1; e.ext_op = 2'd1; e.mem_load = 1'b1;
    e.mem_size = 2'd1;                                         add("lhu", 32'h94410000, e);
    e = '0; e.alu_src_b = 1'b1; e.ext_op = 2'd1; e.mem_we = 1'b1; e.mem_size = 2'd1;
    add("sh", 32'hA4410000, e);
    e = '0; e.ri = 1'b1;                                       add("op3f", 32'hFC000000, e);
    e = '0; e.reg_we = 1'b1; e.reg_dst = 2'd1; e.alu_op = 4'd8; add("nop", 32'h00000000, e);
    e = '0; e.reg_we = 1'b1; e.reg_dst = 2'd1; e.ov_check = 1'b1; add("add", 32'h00221820, e);
    e = '0; e.reg_we = 1'b1; e.reg_dst = 2'd1; e.alu_op = 4'd1;   add("subu", 32'h00221823, e);
    e = '0; e.reg_we = 1'b1; e.reg_dst = 2'd1; e.alu_op = 4'd10; e.shamt_sel = 1'b1;
    add("srav", 32'h00221807, e);
    e = '0; e.j_type = 2'd2; e.bor_j = 1'b1;                   add("jr", 32'h03E00008, e);
    e = '0; e.reg_we = 1'b1; e.reg_dst = 2'd1; e.wd_sel = 3'd2; e.j_type = 2'd2; e.bor_j = 1'b1;
    add("jalr", 32'h0020F809, e);
    e = '0; e.ri = 1'b1;                                       add("funct01", 32'h00000001, e);
    e = '0; e.reg_we = 1'b1; e.alu_src_b = 1'b1; e.ext_op = 2'd1; e.ov_check = 1'b1;
    add("addi", 32'h20010005, e);
    e = '0; e.reg_we = 1'b1; e.alu_src_b = 1'b1; e.alu_op = 4'd3; add("ori", 32'h34010005, e);
    e = '0; e.reg_we = 1'b1; e.alu_src_b = 1'b1; e.ext_op = 2'd2; e.alu_op = 4'd3;
    add("lui", 32'h3C011234, e);
    e = '0; e.reg_we = 1'b1; e.alu_src_b = 1'b1; e.ext_op = 2'd1; e.alu_op = 4'd7;
    add("sltiu", 32'h2C010005, e);
    e = '0; e.br_type = 3'd1; e.bor_j = 1'b1;                  add("beq", 32'h10220003, e);
    e = '0; e.br_type = 3'd6; e.bor_j = 1'b1;                  add("bgez", 32'h04210003, e);
    e = '0; e.ri = 1'b1;                                       add("regimm_rt2", 32'h04220003, e);
`ifdef DECODER_MDU_EN
    e = '0; e.md_op = 4'd1;                                    add("mult", 32'h00850018, e);
    e = '0; e.reg_we = 1'b1; e.reg_dst = 2'd1; e.wd_sel = 3'd3; e.md_op = 4'd7;
    add("mfhi", 32'h00001810, e);
`else
    e = '0; e.ri = 1'b1;                                       add("mult", 32'h00850018, e);
    e = '0; e.ri = 1'b1;                                       add("mfhi", 32'h00001810, e);
`endif

    // ---------------- reset state ----------------
    reset = 1'b1;
    Instr = 32'h40806000;
    @(posedge clk); @(posedge clk); #1;
    check("reset_q", {60'd0, RI_q, ERET_q, CP0WE_q, BorJ_q}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- table: combinational + one-cycle flags ----------------
    foreach (tbl[k]) begin
      @(negedge clk);
      Instr = tbl[k].instr;
      #1;
      check(tbl[k].name, {30'd0, act}, {30'd0, tbl[k].exp});
      @(posedge clk); #1;
      check({tbl[k].name, "_q"}, {60'd0, RI_q, ERET_q, CP0WE_q, BorJ_q},
            {60'd0, flags_of(tbl[k].exp)});
    end

    // ---------------- latency: flag held until the next edge ----------------
    @(negedge clk);
    Instr = 32'h40806000;
    @(posedge clk); #1;
    check("mtc0_cp0we_q", {63'd0, CP0WE_q}, 64'd1);
    @(negedge clk);
    Instr = 32'h00000000;
    #1;
    check("cp0we_q_hold", {63'd0, CP0WE_q}, 64'd1);
    @(posedge clk); #1;
    check("cp0we_q_clear", {63'd0, CP0WE_q}, 64'd0);

    // ---------------- reset wins over a pending flag ----------------
    @(negedge clk);
    Instr = 32'hFC000000;
    @(posedge clk); #1;
    check("ri_q_set", {63'd0, RI_q}, 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ri_comb_in_reset", {63'd0, RI}, 64'd1);
    @(posedge clk); #1;
    check("reset_clears_q", {60'd0, RI_q, ERET_q, CP0WE_q, BorJ_q}, 64'd0);

    // ERET_q and BorJ_q through reset as well
    @(negedge clk);
    reset = 1'b0;
    Instr = 32'h42000018;
    @(posedge clk); #1;
    check("eret_q_set", {60'd0, RI_q, ERET_q, CP0WE_q, BorJ_q}, 64'd4);
    @(negedge clk);
    Instr = 32'h0C000004;
    @(posedge clk); #1;
    check("borj_q_set", {60'd0, RI_q, ERET_q, CP0WE_q, BorJ_q}, 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_clears_borj_q", {63'd0, BorJ_q}, 64'd0);
    check("jal_comb_in_reset", {63'd0, BorJ}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
